// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch definitions: entry layout, pc step and in_num encodings.
// The entry field offsets are also used by decode to unpack queue entries.
package fetch_inst_queue_pkg;

    localparam int IQ_ENTRY_W     = 64;
    localparam int ENTRY_INST_LSB = 0;
    localparam int ENTRY_INST_W   = 32;
    localparam int ENTRY_PC_LSB   = 32;
    localparam int ENTRY_PC_W     = 32;

    localparam logic [31:0] PC_INC = 32'd4;

    localparam logic [1:0] NUM_ONE = 2'd1;
    localparam logic [1:0] NUM_TWO = 2'd2;

    typedef logic [IQ_ENTRY_W-1:0] iq_entry_t;

    function automatic iq_entry_t entry_pack(input logic [31:0] pc, input logic [31:0] inst);
        iq_entry_t e;
        e = '0;
        e[ENTRY_PC_LSB +: ENTRY_PC_W]     = pc;
        e[ENTRY_INST_LSB +: ENTRY_INST_W] = inst;
        return e;
    endfunction

    function automatic logic [31:0] entry_pc(input iq_entry_t e);
        return e[ENTRY_PC_LSB +: ENTRY_PC_W];
    endfunction

    function automatic logic [31:0] entry_inst(input iq_entry_t e);
        return e[ENTRY_INST_LSB +: ENTRY_INST_W];
    endfunction

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch group in, two decode slots out.
// master = fetch/decode side, slave = the queue.
interface fetch_inst_queue_if #(
    parameter int PTR_W = 3
);
    logic             flush;
    logic             in_valid;
    logic [1:0]       in_num;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst0;
    logic [31:0]      in_inst1;
    logic             in_ready;
    logic             out_valid0;
    logic             out_valid1;
    logic [31:0]      out_pc0;
    logic [31:0]      out_inst0;
    logic [31:0]      out_pc1;
    logic [31:0]      out_inst1;
    logic [1:0]       out_accept;
    logic [PTR_W:0]   count;

    modport master (
        output flush, in_valid, in_num, in_pc, in_inst0, in_inst1, out_accept,
        input  in_ready, out_valid0, out_valid1, out_pc0, out_inst0, out_pc1, out_inst1, count
    );

    modport slave (
        input  flush, in_valid, in_num, in_pc, in_inst0, in_inst1, out_accept,
        output in_ready, out_valid0, out_valid1, out_pc0, out_inst0, out_pc1, out_inst1, count
    );

endinterface

// File: rtl/fetch_iq_storage.sv
// Instruction queue entry array: two write ports (tail, tail+1) and two
// asynchronous read ports (head, head+1). Contents are not reset.
module fetch_iq_storage
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             wr0_en,
    input  logic [PTR_W-1:0] wr0_addr,
    input  iq_entry_t        wr0_data,
    input  logic             wr1_en,
    input  logic [PTR_W-1:0] wr1_addr,
    input  iq_entry_t        wr1_data,
    input  logic [PTR_W-1:0] rd0_addr,
    output iq_entry_t        rd0_data,
    input  logic [PTR_W-1:0] rd1_addr,
    output iq_entry_t        rd1_data
);

    iq_entry_t mem_q [DEPTH];
    iq_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr0_en) mem_d[wr0_addr] = wr0_data;
        if (wr1_en) mem_d[wr1_addr] = wr1_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd0_data = mem_q[rd0_addr];
    assign rd1_data = mem_q[rd1_addr];

endmodule

// File: rtl/fetch_inst_queue.sv
// Decoupling instruction queue between icache return and decode.
// Optional same-cycle bypass when empty: define FETCH_IQ_BYPASS_EN.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    fetch_inst_queue_if.slave  iq
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0]  enq_num;
    logic [1:0]  wr_num;
    logic [1:0]  deq_num;
    logic [1:0]  avail;
    logic [1:0]  acc_eff;
    logic        in_ready;
    logic        enq_fire;
    logic        out_valid0;
    logic        out_valid1;
    logic        wr0_en;
    logic        wr1_en;
    logic [31:0] pc_hi;
    iq_entry_t   wr0_data;
    iq_entry_t   wr1_data;
    iq_entry_t   rd0_data;
    iq_entry_t   rd1_data;
    iq_entry_t   out_e0;
    iq_entry_t   out_e1;
`ifdef FETCH_IQ_BYPASS_EN
    logic        byp_act;
`endif

    // Registered count only: a same-cycle dequeue never raises in_ready.
    assign in_ready = (count_q <= (PTR_W+1)'(DEPTH - 2));
    assign enq_fire = iq.in_valid & in_ready;
    assign pc_hi    = iq.in_pc + PC_INC;
    assign enq_num  = (iq.in_num == 2'd0)    ? 2'd0 :
                      (iq.in_num == NUM_ONE) ? 2'd1 : 2'd2;

    always_comb begin
        out_valid0 = (count_q != '0);
        out_valid1 = (count_q >= (PTR_W+1)'(2));
        out_e0     = rd0_data;
        out_e1     = rd1_data;
        wr0_data   = entry_pack(iq.in_pc, iq.in_inst0);
        wr1_data   = entry_pack(pc_hi, iq.in_inst1);
        avail      = out_valid1 ? 2'd2 : {1'b0, out_valid0};
        wr_num     = enq_fire ? enq_num : 2'd0;
`ifdef FETCH_IQ_BYPASS_EN
        byp_act = 1'b0;
        if ((count_q == '0) && !iq.flush) begin
            byp_act    = 1'b1;
            out_valid0 = iq.in_valid;
            out_valid1 = iq.in_valid & (enq_num == NUM_TWO);
            out_e0     = wr0_data;
            out_e1     = wr1_data;
            avail      = iq.in_valid ? enq_num : 2'd0;
        end
`endif
        acc_eff = (iq.out_accept > avail) ? avail : iq.out_accept;
        deq_num = acc_eff;
`ifdef FETCH_IQ_BYPASS_EN
        // Bypassed instructions that decode takes are never written.
        if (byp_act) begin
            deq_num = 2'd0;
            wr_num  = wr_num - acc_eff;
            if (acc_eff == 2'd1) wr0_data = wr1_data;
        end
`endif
        wr0_en = !iq.flush && (wr_num != 2'd0);
        wr1_en = !iq.flush && (wr_num == 2'd2);
    end

    always_comb begin
        head_d  = head_q + PTR_W'(deq_num);
        tail_d  = tail_q + PTR_W'(wr_num);
        count_d = count_q + (PTR_W+1)'(wr_num) - (PTR_W+1)'(deq_num);
        if (iq.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk      (clk),
        .wr0_en   (wr0_en),
        .wr0_addr (tail_q),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (tail_q + PTR_W'(1)),
        .wr1_data (wr1_data),
        .rd0_addr (head_q),
        .rd0_data (rd0_data),
        .rd1_addr (head_q + PTR_W'(1)),
        .rd1_data (rd1_data)
    );

    assign iq.in_ready   = in_ready;
    assign iq.out_valid0 = out_valid0;
    assign iq.out_valid1 = out_valid1;
    assign iq.out_pc0    = entry_pc(out_e0);
    assign iq.out_inst0  = entry_inst(out_e0);
    assign iq.out_pc1    = entry_pc(out_e1);
    assign iq.out_inst1  = entry_inst(out_e1);
    assign iq.count      = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue with a queue scoreboard of {pc, inst}.
// Build with FETCH_IQ_BYPASS_EN defined to exercise the bypass path.
module tb_fetch_inst_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    logic [63:0] sb[$];

    fetch_inst_queue_if #(.PTR_W(PTR_W)) iq_if();

    fetch_inst_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .iq     (iq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; checks current outputs against the scoreboard,
    // then applies the cycle's enqueue/dequeue/flush to the scoreboard.
    task automatic cycle(input logic v, input logic [1:0] num, input logic [31:0] pc,
                         input logic [1:0] acc, input logic fl, output logic fired);
        logic [63:0] grp[$];
        logic [63:0] vis[$];
        logic        byp;
        logic        rdy;
        int          nvis;
        int          deq;
        assert (!(v && num == 2'd3)) else $error("illegal in_num=3 driven");
        iq_if.flush      = fl;
        iq_if.in_valid   = v;
        iq_if.in_num     = num;
        iq_if.in_pc      = pc;
        iq_if.in_inst0   = inst_of(pc);
        iq_if.in_inst1   = inst_of(pc + 32'd4);
        iq_if.out_accept = acc;
        grp = {};
        if (v && num != 2'd0) begin
            grp.push_back({pc, inst_of(pc)});
            if (num >= 2'd2) grp.push_back({pc + 32'd4, inst_of(pc + 32'd4)});
        end
        rdy = (sb.size() <= DEPTH - 2);
        byp = 1'b0;
`ifdef FETCH_IQ_BYPASS_EN
        byp = (sb.size() == 0) && !fl;
`endif
        #1;
        chk("count", 64'(iq_if.count), 64'(sb.size()));
        chk("in_ready", 64'(iq_if.in_ready), 64'(rdy));
        if (byp) vis = grp;
        else     vis = sb;
        nvis = (vis.size() > 2) ? 2 : vis.size();
        chk("out_valid0", 64'(iq_if.out_valid0), 64'(nvis >= 1));
        chk("out_valid1", 64'(iq_if.out_valid1), 64'(nvis >= 2));
        if (nvis >= 1) begin
            chk("out_pc0", 64'(iq_if.out_pc0), 64'(vis[0][63:32]));
            chk("out_inst0", 64'(iq_if.out_inst0), 64'(vis[0][31:0]));
        end
        if (nvis >= 2) begin
            chk("out_pc1", 64'(iq_if.out_pc1), 64'(vis[1][63:32]));
            chk("out_inst1", 64'(iq_if.out_inst1), 64'(vis[1][31:0]));
        end
        deq   = (int'(acc) > nvis) ? nvis : int'(acc);
        fired = v && rdy && !fl;
        if (fl) begin
            sb.delete();
        end else if (byp) begin
            for (int k = deq; k < grp.size(); k++) sb.push_back(grp[k]);
        end else begin
            for (int k = 0; k < deq; k++) sb.delete(0);
            if (v && rdy) foreach (grp[k]) sb.push_back(grp[k]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_to(input int n);
        logic f;
        for (int it = 0; it < 20 && sb.size() > n; it++)
            cycle(1'b0, 2'd0, 32'd0, (sb.size() - n >= 2) ? 2'd2 : 2'd1, 1'b0, f);
        chk("drain_level", 64'(iq_if.count), 64'(n));
    endtask

    initial begin
        logic        f;
        logic [31:0] pc;
        int          nfired;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        iq_if.flush      = 1'b0;
        iq_if.in_valid   = 1'b0;
        iq_if.in_num     = 2'd0;
        iq_if.in_pc      = 32'd0;
        iq_if.in_inst0   = 32'd0;
        iq_if.in_inst1   = 32'd0;
        iq_if.out_accept = 2'd0;

        #12;
        chk("rst_count", 64'(iq_if.count), 64'd0);
        chk("rst_valid0", 64'(iq_if.out_valid0), 64'd0);
        chk("rst_valid1", 64'(iq_if.out_valid1), 64'd0);
        chk("rst_ready", 64'(iq_if.in_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // fill with pairs, then hold a group while full
        cycle(1'b1, 2'd2, 32'h1c00_0000, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_0008, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_0010, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_0018, 2'd0, 1'b0, f);
        chk("full_count", 64'(iq_if.count), 64'd8);
        chk("full_ready", 64'(iq_if.in_ready), 64'd0);
        cycle(1'b1, 2'd2, 32'h1c00_0020, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_0020, 2'd0, 1'b0, f);
        chk("held_not_fired", 64'(f), 64'd0);
        cycle(1'b1, 2'd2, 32'h1c00_0020, 2'd2, 1'b0, f);
        chk("deq_no_ready_raise", 64'(f), 64'd0);
        cycle(1'b1, 2'd2, 32'h1c00_0020, 2'd0, 1'b0, f);
        chk("held_group_fired", 64'(f), 64'd1);

        // enqueue 1 while dequeuing 2 at count 3
        drain_to(3);
        cycle(1'b1, 2'd1, 32'h1c00_0100, 2'd2, 1'b0, f);
        chk("mix_count", 64'(iq_if.count), 64'd2);
        chk("mix_pc0", 64'(iq_if.out_pc0), 64'h1c00_0024);
        chk("mix_pc1", 64'(iq_if.out_pc1), 64'h1c00_0100);

        // wrap-around with mixed group sizes
        drain_to(0);
        pc = 32'h1c00_1000;
        nfired = 0;
        for (int it = 0; it < 200 && nfired < 20; it++) begin
            cycle(1'b1, (nfired % 3 == 0) ? 2'd1 : 2'd2, pc,
                  (it % 2 == 0) ? 2'd1 : 2'd2, 1'b0, f);
            if (f) begin
                pc = pc + ((nfired % 3 == 0) ? 32'd4 : 32'd8);
                nfired++;
            end
        end
        chk("wrap_groups", 64'(nfired), 64'd20);
        drain_to(0);

        // flush beats same-cycle enqueue and dequeue
        cycle(1'b1, 2'd2, 32'h1c00_2000, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_2008, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd1, 32'h1c00_2010, 2'd0, 1'b0, f);
        chk("pre_flush_count", 64'(iq_if.count), 64'd5);
        cycle(1'b1, 2'd2, 32'h1c00_2014, 2'd2, 1'b1, f);
        chk("flush_count", 64'(iq_if.count), 64'd0);
        chk("flush_valid0", 64'(iq_if.out_valid0), 64'd0);
        cycle(1'b1, 2'd2, 32'h1c00_0200, 2'd0, 1'b0, f);
        chk("post_flush_pc", 64'(iq_if.out_pc0), 64'h1c00_0200);
        drain_to(0);

        // over-accept at count 1
        cycle(1'b1, 2'd1, 32'h1c00_0300, 2'd0, 1'b0, f);
        cycle(1'b0, 2'd0, 32'd0, 2'd2, 1'b0, f);
        chk("overacc_count", 64'(iq_if.count), 64'd0);
        chk("overacc_valid0", 64'(iq_if.out_valid0), 64'd0);
        cycle(1'b1, 2'd1, 32'h1c00_0310, 2'd0, 1'b0, f);
        chk("overacc_next_pc", 64'(iq_if.out_pc0), 64'h1c00_0310);
        drain_to(0);

`ifdef FETCH_IQ_BYPASS_EN
        cycle(1'b1, 2'd2, 32'h1c00_0040, 2'd1, 1'b0, f);
        chk("byp_count", 64'(iq_if.count), 64'd1);
        chk("byp_rem_pc", 64'(iq_if.out_pc0), 64'h1c00_0044);
        drain_to(0);
`endif

        // asynchronous reset mid-operation
        cycle(1'b1, 2'd2, 32'h1c00_0400, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_0408, 2'd0, 1'b0, f);
        iq_if.in_valid   = 1'b0;
        iq_if.out_accept = 2'd0;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_count", 64'(iq_if.count), 64'd0);
        chk("arst_valid0", 64'(iq_if.out_valid0), 64'd0);
        chk("arst_ready", 64'(iq_if.in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 2'd0, 32'd0, 2'd0, 1'b0, f);
        cycle(1'b1, 2'd2, 32'h1c00_0500, 2'd0, 1'b0, f);
        drain_to(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
